// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Brief    : Flag register, condition decode, 1-cycle branch resolve with PC
//            redirect, multi-cycle flush FSM and 2-bit bimodal predictor.
// Revision : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int ADDR_W       = 32,
  parameter int BHT_DEPTH    = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter int PC_INC       = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flag_we,
  input  logic              flag_z_in,
  input  logic              flag_n_in,
  input  logic              flag_c_in,
  input  logic              flag_v_in,
  input  logic              br_valid,
  output logic              br_ready,
  input  logic [2:0]        br_cond,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              br_pred_taken,
  input  logic [ADDR_W-1:0] pred_pc,
  output logic              pred_taken,
  output logic              pc_source,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic              flush,
  output logic [3:0]        flags
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [CNT_W-1:0] c_flushLoad = CNT_W'(FLUSH_CYCLES - 1);

  localparam logic [0:0] c_stIdle  = 1'b0;
  localparam logic [0:0] c_stFlush = 1'b1;

  localparam logic [2:0] c_condAl = 3'b000;
  localparam logic [2:0] c_condEq = 3'b001;
  localparam logic [2:0] c_condNe = 3'b010;
  localparam logic [2:0] c_condLt = 3'b011;
  localparam logic [2:0] c_condGe = 3'b100;
  localparam logic [2:0] c_condLo = 3'b101;
  localparam logic [2:0] c_condHs = 3'b110;

  logic [3:0]        r_flags;
  logic [0:0]        r_state;
  logic [0:0]        w_stateNext;
  logic [CNT_W-1:0]  r_flushCnt;
  logic              r_pcSource;
  logic [ADDR_W-1:0] r_redirect;

  logic              w_accept;
  logic [3:0]        w_effFlags;
  logic              w_effZ;
  logic              w_effN;
  logic              w_effC;
  logic              w_effV;
  logic              w_taken;
  logic              w_mispredict;
  logic [ADDR_W-1:0] w_fallThrough;
  logic [IDX_W-1:0]  w_predIdx;
  logic [IDX_W-1:0]  w_updIdx;
  logic [BHT_DEPTH-1:0] w_bhtMsb;
  logic              w_unused;

  assign w_accept = br_valid & br_ready;

  // A flag write landing with the branch is forwarded so the branch sees it
  assign w_effFlags = (flag_we && w_accept) ?
                      {flag_z_in, flag_n_in, flag_c_in, flag_v_in} : r_flags;
  assign {w_effZ, w_effN, w_effC, w_effV} = w_effFlags;

  always_comb begin
    w_taken = 1'b0;
    case (br_cond)
      c_condAl: w_taken = 1'b1;
      c_condEq: w_taken = w_effZ;
      c_condNe: w_taken = ~w_effZ;
      c_condLt: w_taken = w_effN ^ w_effV;
      c_condGe: w_taken = ~(w_effN ^ w_effV);
      c_condLo: w_taken = ~w_effC;
      c_condHs: w_taken = w_effC;
      default:  w_taken = 1'b0;
    endcase
  end

  assign w_mispredict  = w_taken ^ br_pred_taken;
  assign w_fallThrough = br_pc + ADDR_W'(PC_INC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags <= 4'b0000;
    end else if (flag_we) begin
      r_flags <= {flag_z_in, flag_n_in, flag_c_in, flag_v_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcSource <= 1'b0;
      r_redirect <= '0;
    end else begin
      r_pcSource <= w_accept & w_mispredict;
      if (w_accept) begin
        r_redirect <= w_taken ? br_target : w_fallThrough;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_stIdle;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      c_stIdle:  if (w_accept && w_mispredict) w_stateNext = c_stFlush;
      c_stFlush: if (r_flushCnt == '0)         w_stateNext = c_stIdle;
      default:   w_stateNext = c_stIdle;
    endcase
  end

  always_comb begin
    flush    = 1'b0;
    br_ready = 1'b0;
    case (r_state)
      c_stIdle:  br_ready = 1'b1;
      c_stFlush: flush    = 1'b1;
      default:   br_ready = 1'b0;
    endcase
  end

  // Loaded with FLUSH_CYCLES-1 so FLUSH lasts FLUSH_CYCLES cycles including the exit one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flushCnt <= '0;
    end else if (w_accept && w_mispredict) begin
      r_flushCnt <= c_flushLoad;
    end else if ((r_state == c_stFlush) && (r_flushCnt != '0)) begin
      r_flushCnt <= r_flushCnt - 1'b1;
    end
  end

  assign w_predIdx = pred_pc[IDX_W+1:2];
  assign w_updIdx  = br_pc[IDX_W+1:2];

  generate
    for (genvar gi = 0; gi < BHT_DEPTH; gi++) begin : g_bht
      logic [1:0] r_ctr;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ctr <= 2'b01;
        end else if (w_accept && (w_updIdx == IDX_W'(gi))) begin
          if (w_taken && (r_ctr != 2'b11)) begin
            r_ctr <= r_ctr + 2'b01;
          end else if (!w_taken && (r_ctr != 2'b00)) begin
            r_ctr <= r_ctr - 2'b01;
          end
        end
      end

      assign w_bhtMsb[gi] = r_ctr[1];
    end
  endgenerate

  // Lookup reads the registered counters, so a same-cycle update is not visible
  assign pred_taken  = w_bhtMsb[w_predIdx];
  assign pc_source   = r_pcSource;
  assign redirect_pc = r_redirect;
  assign flags       = r_flags;

  assign w_unused = ^{pred_pc, br_pc};

endmodule
`default_nettype wire
